// File: rtl/mcpu_video_pkg.sv
// Shared video-path types and helpers: fetch FSM states, default hvsync timing,
// and constant functions that derive line-buffer geometry from pixel format.
package mcpu_video_pkg;

  typedef enum logic {IDLE, FETCH} fetch_state_e;

  localparam int DEF_H_TOTAL = 309;
  localparam int DEF_V_TOTAL = 262;
  localparam int WORD_W      = 32;

  function automatic int log2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ppw_f(input int bpp);
    return WORD_W / bpp;
  endfunction

  function automatic int wpl_f(input int fb_w, input int bpp);
    return (fb_w * bpp) / WORD_W;
  endfunction

  function automatic int addr_w_f(input int n);
    return (n > 1) ? log2_f(n) : 1;
  endfunction

endpackage

// File: rtl/mcpu_fb_linebuf.sv
// Ping-pong line buffer: two banks of WPL 32-bit words, one synchronous write
// port into the bank being fetched and one asynchronous read port for scanout.
module mcpu_fb_linebuf #(
  parameter int WPL = 16,
  parameter int AW  = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] bank_q [2][WPL];

  always_ff @(posedge clk_i) begin
    if (we_i) bank_q[wr_bank_i][wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = bank_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/mcpu_fb_scanout.sv
// Framebuffer scanout: prefetches one row per scaled line over a req/ack port
// into a ping-pong buffer and serialises packed pixels to rgb in step with
// hpos/vpos. Optional palette lookup when MCPU_FB_PALETTE_EN is defined.
module mcpu_fb_scanout
  import mcpu_video_pkg::*;
#(
  parameter int BPP          = 4,
  parameter int SCALE        = 2,
  parameter int FB_W         = 128,
  parameter int FB_H         = 120,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int OUT_W        = 4,
  parameter int BORDER_COLOR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       hpos,
  input  logic [8:0]       vpos,
  input  logic             display_on,
  input  logic [31:0]      base_addr,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_data,
  output logic [OUT_W-1:0] rgb,
  output logic             underrun
`ifdef MCPU_FB_PALETTE_EN
  ,
  input  logic             pal_we,
  input  logic [3:0]       pal_idx,
  input  logic [OUT_W-1:0] pal_data
`endif
);

  localparam int PPW     = ppw_f(BPP);
  localparam int WPL     = wpl_f(FB_W, BPP);
  localparam int AW      = addr_w_f(WPL);
  localparam int LOG_S   = log2_f(SCALE);
  localparam int LOG_PPW = log2_f(PPW);
  localparam int LOG_BPP = log2_f(BPP);
  localparam logic [31:0]   WIN_W  = 32'(FB_W * SCALE);
  localparam logic [31:0]   WIN_H  = 32'(FB_H * SCALE);
  localparam logic [AW-1:0] LAST_W = AW'(WPL - 1);

  function automatic logic [OUT_W-1:0] fit_out(input logic [BPP-1:0] p);
    return OUT_W'(p);
  endfunction

  logic [31:0] h32, v32, nv32, row32, px32, slot32;
  logic        row_start, trigger, swap_time, in_win;

  always_comb begin
    h32       = {23'd0, hpos};
    v32       = {23'd0, vpos};
    nv32      = (v32 == 32'(V_TOTAL - 1)) ? 32'd0 : v32 + 32'd1;
    row_start = (nv32 < WIN_H) && ((nv32 & 32'(SCALE - 1)) == 32'd0);
    trigger   = (h32 == WIN_W) && row_start;
    swap_time = (h32 == 32'(H_TOTAL - 1));
    row32     = nv32 >> LOG_S;
    in_win    = display_on && (h32 < WIN_W) && (v32 < WIN_H);
    px32      = h32 >> LOG_S;
    slot32    = px32 & 32'(PPW - 1);
  end

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    w_q, w_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             front_q, front_d;
  logic             fbank_q, fbank_d;
  logic             pend_q, pend_d;
  logic             underrun_q, underrun_d;
  logic [OUT_W-1:0] rgb_q, rgb_d;
  logic             buf_we, done, pend;
  logic [AW-1:0]    rd_addr;
  logic [31:0]      rd_data;
  logic [BPP-1:0]   pixel;
  logic [OUT_W-1:0] mapped;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    front_d    = front_q;
    fbank_d    = fbank_q;
    underrun_d = underrun_q;
    buf_we     = 1'b0;
    done       = 1'b0;

    if (state_q == FETCH && mem_ack) begin
      buf_we = !reset;
      if (w_q == LAST_W) begin
        done      = 1'b1;
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end else begin
        w_d        = w_q + AW'(1);
        mem_addr_d = mem_addr_q + 32'd1;
      end
    end

    // A fetch that lands in the bank already on display (after a forced swap)
    // must not schedule another swap, or the stale bank would come back.
    pend   = pend_q | (done && (fbank_q != front_q));
    pend_d = pend;
    if (swap_time) begin
      if (pend) begin
        front_d = ~front_q;
        pend_d  = 1'b0;
      end else if (row_start && state_q == FETCH) begin
        front_d    = ~front_q;
        underrun_d = 1'b1;
      end
    end

    if (trigger) begin
      if (state_q == FETCH) underrun_d = 1'b1;
      state_d    = FETCH;
      w_d        = '0;
      mem_req_d  = 1'b1;
      mem_addr_d = base_addr + row32 * 32'(WPL);
      fbank_d    = ~front_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      w_q        <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      front_q    <= 1'b0;
      fbank_q    <= 1'b1;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      front_q    <= front_d;
      fbank_q    <= fbank_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      rgb_q      <= rgb_d;
    end
  end

  mcpu_fb_linebuf #(
    .WPL(WPL),
    .AW (AW)
  ) u_linebuf (
    .clk_i    (clk),
    .we_i     (buf_we),
    .wr_bank_i(fbank_q),
    .wr_addr_i(w_q),
    .wr_data_i(mem_data),
    .rd_bank_i(front_q),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

`ifdef MCPU_FB_PALETTE_EN
  logic [OUT_W-1:0] pal_q [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 16; n++) pal_q[n] <= OUT_W'(n);
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_data;
    end
  end

  assign mapped = pal_q[4'(pixel)];
`else
  assign mapped = fit_out(pixel);
`endif

  // Pixel stage: address and slot come straight from hpos, registered into rgb.
  always_comb begin
    rd_addr = in_win ? AW'(px32 >> LOG_PPW) : '0;
    pixel   = BPP'(rd_data >> (slot32 << LOG_BPP));
    rgb_d   = in_win ? mapped : OUT_W'(BORDER_COLOR);
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign rgb      = rgb_q;
  assign underrun = underrun_q;

endmodule
